ising_step_ctrl: RTL and testbench

- Sequencer for the sigma·J·sigma energy datapath in the spin-annealing engine.
- Per iteration it proposes a single-spin flip, streams all J column chunks from weight memory into the datapath, and pulses the datapath start.
- After a fixed latency it samples the resulting energy, accepts or rejects the flip against the best energy so far, and loops for a programmed iteration count.

---
 rtl/ising_step_ctrl.sv | 125 ++++++++++++
 tb/tb_ising_step_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ising_step_ctrl.sv
// ising_step_ctrl: per-iteration flip proposal, J chunk streaming and accept/reject sequencing
// for the sigma*J*sigma energy datapath.
module ising_step_ctrl #(
    parameter int VECTOR_SIZE  = 256,
    parameter int NUM_J_CHUNKS = 256,
    parameter int ENERGY_WIDTH = 21,
    parameter int DP_LATENCY   = 2,
    parameter int ITER_WIDTH   = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cfg_start,
    input  logic [ITER_WIDTH-1:0]           cfg_num_iter,
    input  logic [VECTOR_SIZE-1:0]          sigma_init,
    input  logic [ENERGY_WIDTH-1:0]         energy_init,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic                            mem_req_valid,
    input  logic                            mem_req_ready,
    output logic [$clog2(NUM_J_CHUNKS)-1:0] mem_req_addr,
    input  logic                            mem_rsp_valid,
    output logic                            dp_start,
    output logic [VECTOR_SIZE-1:0]          dp_sigma,
    output logic [ENERGY_WIDTH-1:0]         dp_energy_prev,
    input  logic [ENERGY_WIDTH-1:0]         dp_energy,
    output logic [VECTOR_SIZE-1:0]          sigma_best,
    output logic [ENERGY_WIDTH-1:0]         energy_best,
    output logic [ITER_WIDTH-1:0]           iter_cnt
);
    localparam int AW = $clog2(NUM_J_CHUNKS);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(VECTOR_SIZE);
    localparam int LW = $clog2(DP_LATENCY + 1);

    typedef enum logic [2:0] {IDLE, PROPOSE, LOAD, DRAIN, COMPARE, DONE} state_t;
    state_t state, state_nx;

    logic [CW-1:0]         req_cnt, rsp_cnt;
    logic [LW-1:0]         wait_cnt;
    logic [ITER_WIDTH-1:0] num_iter, iter_nx;
    logic                  gap, gap_now, rsp_done, last_iter, accept;

    assign iter_nx   = iter_cnt + ITER_WIDTH'(1);
    assign last_iter = iter_nx == num_iter;
    assign rsp_done  = state == LOAD && mem_rsp_valid && rsp_cnt == CW'(NUM_J_CHUNKS - 1);
    assign gap_now   = state == LOAD && !mem_rsp_valid && rsp_cnt != '0;
    assign accept    = $signed(dp_energy) < $signed(energy_best);

    assign busy           = state != IDLE;
    assign done           = state == DONE;
    assign mem_req_valid  = state == LOAD && req_cnt < CW'(NUM_J_CHUNKS);
    assign mem_req_addr   = req_cnt[AW-1:0];
    assign dp_start       = state == LOAD && mem_rsp_valid && rsp_cnt == '0;
    assign dp_energy_prev = energy_best;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = cfg_start ? (cfg_num_iter == '0 ? DONE : PROPOSE) : IDLE;
            PROPOSE: state_nx = LOAD;
            LOAD:    state_nx = !rsp_done ? LOAD
                              : gap ? (last_iter ? DONE : PROPOSE)
                              : (DP_LATENCY > 1 ? DRAIN : COMPARE);
            DRAIN:   state_nx = wait_cnt <= LW'(1) ? COMPARE : DRAIN;
            COMPARE: state_nx = last_iter ? DONE : PROPOSE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_cnt     <= '0;
            rsp_cnt     <= '0;
            wait_cnt    <= '0;
            gap         <= 1'b0;
            err         <= 1'b0;
            num_iter    <= '0;
            iter_cnt    <= '0;
            dp_sigma    <= '0;
            sigma_best  <= '0;
            energy_best <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && cfg_start) begin
                num_iter    <= cfg_num_iter;
                sigma_best  <= sigma_init;
                energy_best <= energy_init;
                err         <= 1'b0;
                iter_cnt    <= '0;
            end
            if (state == PROPOSE) begin
                dp_sigma <= sigma_best ^ (VECTOR_SIZE'(1) << iter_cnt[FW-1:0]);
                req_cnt  <= '0;
                rsp_cnt  <= '0;
                gap      <= 1'b0;
            end
            if (mem_req_valid && mem_req_ready)
                req_cnt <= req_cnt + CW'(1);
            if (state == LOAD && mem_rsp_valid)
                rsp_cnt <= rsp_cnt + CW'(1);
            if (gap_now) begin
                gap <= 1'b1;
                err <= 1'b1;
            end
            // The last-beat cycle counts as the first latency cycle
            if (rsp_done) begin
                wait_cnt <= LW'(DP_LATENCY - 1);
                if (gap)
                    iter_cnt <= iter_nx;
            end
            if (state == DRAIN)
                wait_cnt <= wait_cnt - LW'(1);
            if (state == COMPARE) begin
                iter_cnt <= iter_nx;
                if (accept) begin
                    sigma_best  <= dp_sigma;
                    energy_best <= dp_energy;
                end
            end
        end
    end
endmodule

// File: tb/tb_ising_step_ctrl.sv
// tb_ising_step_ctrl: directed scoreboard bench for the annealing step sequencer.
module tb_ising_step_ctrl;
    localparam int VS = 256;
    localparam int NC = 256;
    localparam int EW = 21;
    localparam int IW = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 cfg_start = 1'b0;
    logic [IW-1:0]        cfg_num_iter = '0;
    logic [VS-1:0]        sigma_init = '0;
    logic signed [EW-1:0] energy_init = '0;
    logic                 busy, done, err, mem_req_valid, dp_start;
    logic                 mem_req_ready = 1'b0;
    logic                 mem_rsp_valid = 1'b0;
    logic [7:0]           mem_req_addr;
    logic [VS-1:0]        dp_sigma, sigma_best;
    logic signed [EW-1:0] dp_energy_prev, energy_best;
    logic signed [EW-1:0] dp_energy = -21'sd1000;
    logic [IW-1:0]        iter_cnt;

    ising_step_ctrl dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_num_iter(cfg_num_iter),
        .sigma_init(sigma_init), .energy_init(energy_init), .busy(busy), .done(done), .err(err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .dp_start(dp_start), .dp_sigma(dp_sigma),
        .dp_energy_prev(dp_energy_prev), .dp_energy(dp_energy), .sigma_best(sigma_best),
        .energy_best(energy_best), .iter_cnt(iter_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VS-1:0]        sb;
        logic signed [EW-1:0] eb;
        logic [IW-1:0]        it;
        logic                 er;
    } res_t;

    res_t                 res_q[$];
    int                   addr_q[$];
    int                   n_cmp = 0;
    int                   n_bad = 0;
    logic signed [EW-1:0] en [0:3];

    task automatic chk(input string tag, input logic [VS-1:0] obs, input logic [VS-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory/datapath model: requests take the ready pattern, responses are a
    // contiguous 256-beat burst that starts once `lead` requests were accepted;
    // the true energy is presented only two cycles after the last beat.
    task automatic run(input int n, input logic signed [EW-1:0] e0, input logic [VS-1:0] s0,
                       input int lead, input bit bp, input int gap_it, input int exp_done_cyc);
        res_t          r;
        logic [VS-1:0] c;
        int cyc = 0, it = 0, acc = 0, beat = 0, last = 0, starts = 0, done_cyc = -1, ea;
        bit go = 0, skipped = 0;
        r.sb = s0;
        r.eb = e0;
        r.it = IW'(n);
        r.er = gap_it >= 0 && gap_it < n;
        for (int i = 0; i < n; i++) begin
            c = r.sb;
            c[i % VS] = ~c[i % VS];
            if (i != gap_it && en[i] < r.eb) begin
                r.sb = c;
                r.eb = en[i];
            end
            for (int a = 0; a < NC; a++) addr_q.push_back(a);
        end
        res_q.push_back(r);
        while (done_cyc < 0 && cyc < 5000) begin
            @(negedge clk);
            cfg_start     = cyc == 0;
            cfg_num_iter  = IW'(n);
            sigma_init    = s0;
            energy_init   = e0;
            mem_req_ready = bp ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
            mem_rsp_valid = 1'b0;
            if (go && beat < NC) begin
                if (it == gap_it && beat == 11 && !skipped) skipped = 1;
                else begin
                    mem_rsp_valid = 1'b1;
                    beat++;
                    if (beat == NC) last = cyc;
                end
            end
            dp_energy = (beat == NC && cyc == last + 2) ? en[it] : -21'sd1000;
            if (beat == NC && cyc == last + 2) begin
                it++;
                acc = 0;
                beat = 0;
                go = 0;
                skipped = 0;
            end
            #1;
            if (cyc == 1) begin
                chk("err_cleared_at_start", err, 0);
                chk("busy_after_start", busy, 1);
            end
            if (mem_req_valid && mem_req_ready) begin
                ea = addr_q.size() != 0 ? addr_q.pop_front() : -1;
                chk("req_addr", mem_req_addr, ea);
                acc++;
                if (acc >= lead) go = 1;
            end
            if (dp_start) starts++;
            if (done) done_cyc = cyc;
            cyc++;
        end
        chk("done_seen", done_cyc >= 0, 1);
        if (exp_done_cyc >= 0) chk("done_cycle", done_cyc, exp_done_cyc);
        r = res_q.pop_front();
        chk("sigma_best", sigma_best, r.sb);
        chk("energy_best", energy_best, r.eb);
        chk("dp_energy_prev", dp_energy_prev, r.eb);
        chk("iter_cnt", iter_cnt, r.it);
        chk("err", err, r.er);
        chk("dp_start_count", starts, n);
        chk("missing_reqs", addr_q.size(), 0);
        addr_q.delete();
        @(negedge clk);
        #1;
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_dp_start", dp_start, 0);
        chk("rst_addr", mem_req_addr, 0);
        chk("rst_iter", iter_cnt, 0);
        chk("rst_sigma_best", sigma_best, 0);
        chk("rst_energy_best", energy_best, 0);
        chk("rst_dp_sigma", dp_sigma, 0);
        rst = 1'b0;

        en[0] = 21'sd90;
        run(1, 21'sd100, {8{32'hA5C3_0F1E}}, 1, 0, -1, -1);
        en[0] = 21'sd100;
        run(1, 21'sd100, {8{32'hA5C3_0F1E}}, 1, 0, -1, -1);
        en[0] = -21'sd5;
        run(1, 21'sd100, {8{32'h1234_5678}}, 200, 1, -1, -1);
        en[0] = 21'sd70;
        en[1] = 21'sd80;
        run(2, 21'sd100, {8{32'hDEAD_BEEF}}, 1, 0, 0, -1);
        en[0] = 21'sd50;
        en[1] = 21'sd40;
        en[2] = 21'sd45;
        run(3, 21'sd60, {8{32'h0F0F_00F0}}, 1, 0, -1, -1);
        run(0, -21'sd7, {8{32'hCAFE_F00D}}, 1, 0, -1, 1);

        @(negedge clk);
        cfg_start     = 1'b1;
        cfg_num_iter  = 16'd4;
        sigma_init    = {8{32'h5555_AAAA}};
        energy_init   = 21'sd33;
        mem_req_ready = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("mid_load_req_valid", mem_req_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_req_valid", mem_req_valid, 0);
        chk("mid_rst_addr", mem_req_addr, 0);
        chk("mid_rst_sigma_best", sigma_best, 0);
        chk("mid_rst_energy_best", energy_best, 0);
        chk("mid_rst_dp_sigma", dp_sigma, 0);
        chk("mid_rst_iter", iter_cnt, 0);
        chk("mid_rst_done", done, 0);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
